// File: rtl/rx_driver_pkg.sv
// rx_driver_pkg: shared types and constants for the UART receive driver.
//   rx_state_t : handshake FSM state encoding
//   ASCII_CR   : carriage return, the default end-of-message byte
//   ERR_MAX    : saturation value of the errored-byte counter
package rx_driver_pkg;

  typedef enum logic [2:0] {
    RX_INIT  = 3'd0,
    RX_IDLE  = 3'd1,
    RX_STORE = 3'd2,
    RX_ECHO  = 3'd3,
    RX_ACK   = 3'd4
  } rx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ERR_MAX  = 8'hFF;

endpackage

// File: rtl/rx_buffer_ram.sv
// rx_buffer_ram: simple dual-port byte RAM for the receive message buffer.
// Synchronous write; registered read with read-before-write behaviour.
// Ports:
//   Clock, Reset        clock, synchronous active-high reset (read register only)
//   WrEn_i              write strobe
//   WrAddr_i, WrData_i  write address / data
//   RdAddr_i            read address, sampled every cycle
//   RdData_o            read data, one cycle after RdAddr_i
module rx_buffer_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WrEn_i,
  input  logic [ADDR_W-1:0] WrAddr_i,
  input  logic [7:0]        WrData_i,
  input  logic [ADDR_W-1:0] RdAddr_i,
  output logic [7:0]        RdData_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Contents are never cleared; only the read register resets.
  always_ff @(posedge Clock) begin
    if (WrEn_i) mem_q[WrAddr_i] <= WrData_i;
  end

  // Non-blocking update of mem_q means a same-cycle read sees the old byte.
  always_ff @(posedge Clock) begin
    if (Reset) rd_data_q <= '0;
    else       rd_data_q <= mem_q[RdAddr_i];
  end

  assign RdData_o = rd_data_q;

endmodule

// File: rtl/rx_driver.sv
// rx_driver: takes bytes from the UART receiver over a valid/acknowledge
// handshake, stores them in a 2**ADDR_W byte buffer, detects the
// end-of-message byte, counts errored bytes and exposes the buffer through
// a registered read port.
// Optional build macro RX_ECHO_EN: echoes every non-errored byte (terminator
// and overflow-dropped bytes included) to the UART transmitter before the
// byte is acknowledged.
// Ports:
//   Clock, Reset     clock, synchronous active-high reset
//   RxValid/RxData/RxError  byte from receiver (held until RxAck)
//   RxAck            acknowledge of current byte
//   RdAddr/RdData    buffer read port, 1-cycle latency
//   MsgDone          one-cycle pulse, MsgLen valid in the same cycle
//   MsgLen           length of last completed message (0..DEPTH)
//   Overflow         sticky: a byte was dropped on a full buffer
//   ErrCount         saturating count of errored bytes
//   EchoGo/EchoData/EchoEmpty  transmitter echo handshake (RX_ECHO_EN only)
module rx_driver
  import rx_driver_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RxValid,
  input  logic [7:0]        RxData,
  input  logic              RxError,
  output logic              RxAck,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [7:0]        RdData,
`ifdef RX_ECHO_EN
  output logic              EchoGo,
  output logic [7:0]        EchoData,
  input  logic              EchoEmpty,
`endif
  output logic              MsgDone,
  output logic [ADDR_W:0]   MsgLen,
  output logic              Overflow,
  output logic [7:0]        ErrCount
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

  rx_state_t         state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   msg_len_q, msg_len_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              ovf_q, ovf_d;
  logic              msg_done_q, msg_done_d;
  logic              ram_we;
`ifdef RX_ECHO_EN
  logic              echo_go_q, echo_go_d;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    msg_len_d  = msg_len_q;
    err_cnt_d  = err_cnt_q;
    ovf_d      = ovf_q;
    msg_done_d = 1'b0;
    ram_we     = 1'b0;
`ifdef RX_ECHO_EN
    echo_go_d  = echo_go_q;
`endif
    case (state_q)
      RX_INIT: begin
        wr_ptr_d  = '0;
        msg_len_d = '0;
        err_cnt_d = '0;
        ovf_d     = 1'b0;
`ifdef RX_ECHO_EN
        echo_go_d = 1'b0;
`endif
        state_d   = RX_IDLE;
      end
      RX_IDLE: begin
        if (RxValid) state_d = RX_STORE;
      end
      RX_STORE: begin
        // Error wins over terminator and full checks.
        if (RxError) begin
          err_cnt_d = sat_inc(err_cnt_q);
        end else if (RxData == TERM_CHAR) begin
          msg_len_d  = wr_ptr_q;
          wr_ptr_d   = '0;
          msg_done_d = 1'b1;
        end else if (wr_ptr_q == FULL) begin
          ovf_d = 1'b1;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
`ifdef RX_ECHO_EN
        state_d = RxError ? RX_ACK : RX_ECHO;
`else
        state_d = RX_ACK;
`endif
      end
`ifdef RX_ECHO_EN
      RX_ECHO: begin
        // Wait for an empty transmitter, then hold EchoGo until it goes busy.
        if (!echo_go_q) begin
          if (EchoEmpty) echo_go_d = 1'b1;
        end else if (!EchoEmpty) begin
          echo_go_d = 1'b0;
          state_d   = RX_ACK;
        end
      end
`endif
      RX_ACK: begin
        if (!RxValid) state_d = RX_IDLE;
      end
      default: state_d = RX_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= RX_INIT;
      wr_ptr_q   <= '0;
      msg_len_q  <= '0;
      err_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      msg_done_q <= 1'b0;
`ifdef RX_ECHO_EN
      echo_go_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      msg_len_q  <= msg_len_d;
      err_cnt_q  <= err_cnt_d;
      ovf_q      <= ovf_d;
      msg_done_q <= msg_done_d;
`ifdef RX_ECHO_EN
      echo_go_q  <= echo_go_d;
`endif
    end
  end

  rx_buffer_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clock    (Clock),
    .Reset    (Reset),
    .WrEn_i   (ram_we),
    .WrAddr_i (wr_ptr_q[ADDR_W-1:0]),
    .WrData_i (RxData),
    .RdAddr_i (RdAddr),
    .RdData_o (RdData)
  );

  // Ack drops in the same cycle the receiver releases RxValid, so a new byte
  // can be presented immediately afterwards.
  assign RxAck    = (state_q == RX_ACK) && RxValid;
  // MsgDone is registered alongside MsgLen so both are valid together.
  assign MsgDone  = msg_done_q;
  assign MsgLen   = msg_len_q;
  assign Overflow = ovf_q;
  assign ErrCount = err_cnt_q;
`ifdef RX_ECHO_EN
  assign EchoGo   = echo_go_q;
  // RxData is held stable until RxAck, which comes after the echo.
  assign EchoData = RxData;
`endif

endmodule

// File: doc/rx_driver.md
Name: rx_driver

Overview:
- Receive-side counterpart of the UART transmit driver.
- Takes bytes from the UART receiver over a valid/acknowledge handshake and stores them in a 256-byte buffer RAM.
- Detects the end-of-message terminator, counts errored bytes, and exposes completed messages through a registered read port.
- Sits between the UART receiver and downstream consumer logic (display/command parser).

Parameters:
- ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W bytes.
- TERM_CHAR, 8'h0D, end-of-message byte; never stored.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- RxValid  in  1  UART receiver holds a byte; held high until RxAck observed
- RxData  in  8  received byte, stable while RxValid high
- RxError  in  1  framing/parity error on current byte, qualified by RxValid
- RxAck  out  1  driver acknowledges current byte
- RdAddr  in  ADDR_W  buffer read address
- RdData  out  8  registered buffer data
- MsgDone  out  1  one-cycle pulse: message complete
- MsgLen  out  ADDR_W+1  length of last completed message, 0..DEPTH
- Overflow  out  1  sticky: byte dropped because buffer full
- ErrCount  out  8  saturating count of errored bytes

Behaviour:
- Reset values: RxAck=0, MsgDone=0, MsgLen=0, Overflow=0, ErrCount=0, RdData=0, write pointer WrPtr=0, state RX_INIT. RAM contents are not cleared.
- Reset asserted mid-handshake aborts the handshake. Any pending byte is left unacknowledged; the receiver re-presents it.
- FSM states:
  - RX_INIT: clear WrPtr and outputs; go to RX_IDLE next cycle.
  - RX_IDLE: when RxValid=1, go to RX_STORE.
  - RX_STORE: classify the byte, one cycle:
    - RxError=1: byte discarded; ErrCount += 1, saturating at 255. Takes priority over terminator and full checks.
    - RxData==TERM_CHAR: byte not stored; MsgLen <= WrPtr; WrPtr <= 0; MsgDone=1 for exactly this cycle.
    - Else if WrPtr==DEPTH (full): byte dropped; Overflow <= 1.
    - Else: RAM[WrPtr] <= RxData; WrPtr += 1.
    - Go to RX_ACK.
  - RX_ACK: RxAck=1 held while RxValid=1. When RxValid=0, drop RxAck and return to RX_IDLE.
- WrPtr is ADDR_W+1 bits wide and saturates at DEPTH; it never wraps.
- Terminator with WrPtr=0 gives MsgDone with MsgLen=0 (empty message is legal).
- After a full buffer, the terminator still reports MsgLen=DEPTH and resets WrPtr. Overflow stays set until Reset.
- Throughput: at most one byte per 3 cycles plus the receiver's RxValid release time.
- Read port:
  - RdData <= RAM[RdAddr] every cycle; 1-cycle latency.
  - Simultaneous write and read of the same address returns the old data (read-before-write).
  - Reads are allowed at any time, including while a message is being written.
- Unreachable state encodings go to RX_INIT.

Optional Feature:
- Macro: RX_ECHO_EN.
- Enabled:
  - Adds ports EchoGo (out 1), EchoData (out 8), EchoEmpty (in 1), for connection to the UART transmitter.
  - After RX_STORE, every non-errored byte, including the terminator, is echoed in new state RX_ECHO. It applies to bytes dropped on overflow too.
  - RX_ECHO waits for EchoEmpty=1, then drives EchoData=byte and holds EchoGo=1 until EchoEmpty=0.
  - It then drops EchoGo and proceeds to RX_ACK, so RxAck is delayed until the echo is accepted.
  - EchoGo resets to 0.
- Disabled: no echo ports and no RX_ECHO state; RX_STORE goes directly to RX_ACK.

Decomposition:
- Package rx_driver_pkg holds:
  - state enum rx_state_t (RX_INIT, RX_IDLE, RX_STORE, RX_ECHO, RX_ACK);
  - constant ASCII_CR = 8'h0D;
  - constant ERR_MAX = 8'hFF.
- Sub-module rx_buffer_ram: simple dual-port RAM with synchronous write, registered read-before-write, parameterised ADDR_W.

Test Plan:
- Send "HI\r" (8'h48, 8'h49, 8'h0D) with the receiver model releasing RxValid one cycle after RxAck:
  - MsgDone pulses once with MsgLen=2;
  - RdAddr=0 gives RdData=8'h48 and RdAddr=1 gives 8'h49, each one cycle after the address is applied;
  - RxAck shows exactly 3 handshakes.
- Send 8'h0D alone: MsgDone pulses with MsgLen=0; RAM is unchanged.
- Send 257 bytes of 8'hAA, then 8'h0D:
  - Overflow rises on byte 257;
  - MsgLen=256; RAM[255]=8'hAA;
  - Overflow stays 1 through a following message "A\r".
- Send 3 bytes with RxError=1, then "Z\r":
  - ErrCount=3; MsgLen=1; RAM[0]=8'h5A.
  - Separately, drive 300 errored bytes: ErrCount=255.
- Assert Reset for 1 cycle while in RX_ACK with RxValid still high:
  - RxAck=0, MsgLen=0, ErrCount=0 the next cycle;
  - the held byte is re-processed after Reset releases.
- With RX_ECHO_EN and EchoEmpty held 0 for 20 cycles:
  - no RxAck until EchoEmpty=1;
  - then EchoGo=1 with EchoData=8'h48, then RxAck.
